// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an asynchronous PWM input.
// The input is synchronized and edge-detected. A three-state FSM counts clock
// cycles from one rising edge to the next. Each completed period is published
// with a one-cycle valid pulse. A waveform that stops toggling is reported
// through the stuck / stuck_level status outputs.
//
// Handshake: valid is a one-cycle strobe with no back-pressure. period and
// high_time carry their new values in exactly the cycle valid is high, and
// they hold those values until the next strobe. There is no ready signal.
// The consumer must sample in the valid cycle.
//
// SYNC_STAGES must be at least 2. The first stage is the metastability
// catcher and the last stage feeds the edge-detect history flop.
module pwm_capture #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      HIGH      = 2'd1,
      LOW       = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // ------------------------------------------------------------------
   // Synchronizer and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   s_lvl;
   logic                   rise;
   logic                   fall;

   // Shift the raw pin into the chain; the history flop trails the last stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // Both edges see identical pipeline depth, so high and low times are unbiased.
   always_comb begin
      s_lvl = sync_q[SYNC_STAGES-1];
      rise  = s_lvl & ~hist_q;
      fall  = ~s_lvl & hist_q;
   end

   // Synchronizer and history registers, cleared so a high pin produces a rise after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   // ------------------------------------------------------------------
   // Measurement FSM
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;
   logic             level_q, level_d;

   logic [CNT_W-1:0] per_inc;
   logic [CNT_W-1:0] hi_inc;
   logic             per_at_max;

   // Saturating increments: counters park at CNT_MAX instead of wrapping.
   always_comb begin
      per_at_max = (per_q == CNT_MAX);
      per_inc    = per_at_max ? CNT_MAX : per_q + CNT_ONE;
      hi_inc     = (hi_q == CNT_MAX) ? CNT_MAX : hi_q + CNT_ONE;
   end

   // Next-state logic. A rise always beats saturation in the same cycle.
   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      hi_d     = hi_q;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
      stuck_d  = stuck_q;
      level_d  = level_q;

      unique case (state_q)
         WAIT_RISE: begin
            // Falls are only noted for stuck_level. A rise starts a fresh
            // measurement and clears any stuck report.
            if (rise) begin
               state_d = HIGH;
               per_d   = CNT_ONE;
               hi_d    = CNT_ONE;
               stuck_d = 1'b0;
            end else if (fall) begin
               level_d = 1'b0;
            end
         end

         HIGH: begin
            if (fall) begin
               // High time freezes at its current value; the period keeps counting.
               state_d = LOW;
               per_d   = per_inc;
            end else if (per_at_max) begin
               state_d  = WAIT_RISE;
               per_d    = '0;
               hi_d     = '0;
               period_d = CNT_MAX;
               high_d   = s_lvl ? CNT_MAX : '0;
               valid_d  = 1'b1;
               stuck_d  = 1'b1;
               level_d  = s_lvl;
            end else begin
               per_d = per_inc;
               hi_d  = hi_inc;
            end
         end

         LOW: begin
            if (rise) begin
               // Closing rise: publish, then this same rise opens the next period.
               state_d  = HIGH;
               period_d = per_q;
               high_d   = hi_q;
               valid_d  = 1'b1;
               per_d    = CNT_ONE;
               hi_d     = CNT_ONE;
            end else if (per_at_max) begin
               state_d  = WAIT_RISE;
               per_d    = '0;
               hi_d     = '0;
               period_d = CNT_MAX;
               high_d   = s_lvl ? CNT_MAX : '0;
               valid_d  = 1'b1;
               stuck_d  = 1'b1;
               level_d  = s_lvl;
            end else begin
               per_d = per_inc;
            end
         end

         default: begin
            state_d = WAIT_RISE;
            per_d   = '0;
            hi_d    = '0;
         end
      endcase
   end

   // FSM, counter and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= WAIT_RISE;
         per_q    <= '0;
         hi_q     <= '0;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         stuck_q  <= 1'b0;
         level_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         hi_q     <= hi_d;
         period_q <= period_d;
         high_q   <= high_d;
         valid_q  <= valid_d;
         stuck_q  <= stuck_d;
         level_q  <= level_d;
      end
   end

   // All outputs come straight from registers.
   always_comb begin
      period      = period_q;
      high_time   = high_q;
      valid       = valid_q;
      stuck       = stuck_q;
      stuck_level = level_q;
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives directed and random PWM waveforms into pwm_capture.
// A timestamp-based reference model predicts every output on every cycle.
module tb_pwm_capture;

   localparam int CNT_W = 8;
   localparam int SYNC  = 2;
   localparam int MAXV  = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic             pwm_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             stuck;
   logic             stuck_level;
   logic [1:0]       dbg_state;

   int checks;
   int errors;
   int vcnt;
   int v0;

   pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .reset       (reset),
      .pwm_in      (pwm_in),
      .period      (period),
      .high_time   (high_time),
      .valid       (valid),
      .stuck       (stuck),
      .stuck_level (stuck_level),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- comparison helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phases: waiting for a first rise, inside the high part, inside the low part.
   localparam int P_WAIT = 0;
   localparam int P_HIGH = 1;
   localparam int P_LOW  = 2;

   bit   sq[$];         // sq[0] is the newest pin sample
   int   phase;
   int   t, t0, hlen, el;
   bit   m_live;
   bit   s, sd, rise, fall, tmo;
   logic [CNT_W-1:0] m_period, m_high;
   logic m_valid, m_stuck, m_level;

   initial m_live = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         sq = {};
         for (int i = 0; i <= SYNC; i++) sq.push_back(1'b0);
         phase = P_WAIT; t = 0; t0 = 0; hlen = 0;
         m_period = '0; m_high = '0; m_valid = 1'b0; m_stuck = 1'b0; m_level = 1'b0;
         m_live = 1'b1;
      end else if (m_live) begin
         // The level the decision logic sees is the pin from SYNC edges ago.
         s    = sq[SYNC-1];
         sd   = sq[SYNC];
         rise = s && !sd;
         fall = !s && sd;
         sq.push_front(pwm_in);
         void'(sq.pop_back());
         m_valid = 1'b0;
         tmo = 1'b0;
         el  = t - t0;   // cycles elapsed since the opening rise
         case (phase)
            P_WAIT: begin
               if (rise) begin phase = P_HIGH; t0 = t; m_stuck = 1'b0; end
               else if (fall) m_level = 1'b0;
            end
            P_HIGH: begin
               if (fall) begin phase = P_LOW; hlen = (el > MAXV) ? MAXV : el; end
               else if (el >= MAXV) tmo = 1'b1;
            end
            default: begin
               if (rise) begin
                  m_period = CNT_W'((el > MAXV) ? MAXV : el);
                  m_high   = CNT_W'(hlen);
                  m_valid  = 1'b1;
                  t0 = t;
                  phase = P_HIGH;
               end else if (el >= MAXV) tmo = 1'b1;
            end
         endcase
         if (tmo) begin
            phase = P_WAIT;
            m_stuck = 1'b1;
            m_level = s;
            m_period = CNT_W'(MAXV);
            m_high = s ? CNT_W'(MAXV) : '0;
            m_valid = 1'b1;
         end
         t++;
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clk) begin
      if (m_live) begin
         chk("valid", 32'(valid), 32'(m_valid));
         chk("period", 32'(period), 32'(m_period));
         chk("high_time", 32'(high_time), 32'(m_high));
         chk("stuck", 32'(stuck), 32'(m_stuck));
         chk("stuck_level", 32'(stuck_level), 32'(m_level));
         if (valid === 1'b1) vcnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic v);
      pwm_in = v;
      @(posedge clk);
      #2;
   endtask

   task automatic wave(input int h, input int l, input int reps);
      repeat (reps) begin
         repeat (h) cyc(1'b1);
         repeat (l) cyc(1'b0);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"}, 32'(period), 0);
      chk({tag, "_high"}, 32'(high_time), 0);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_stuck"}, 32'(stuck), 0);
      chk({tag, "_level"}, 32'(stuck_level), 0);
   endtask

   // ---------------- stimulus with hand-computed anchors ----------------
   initial begin
      int r, h, l, n;
      checks = 0; errors = 0; vcnt = 0;
      reset = 1'b0; pwm_in = 1'b0;
      repeat (5) cyc(1'b0);
      chk_zero("reset");
      reset = 1'b1;

      // 3/7: first valid after the second rise, then one every 10 cycles.
      v0 = vcnt; wave(3, 7, 5);
      chk("w37_count", 32'(vcnt - v0), 4);
      chk("w37_period", 32'(period), 10);
      chk("w37_high", 32'(high_time), 3);

      // Switch to 5/5: one transitional 10/3 sample, then 10/5.
      v0 = vcnt; wave(5, 5, 4);
      chk("w55_count", 32'(vcnt - v0), 4);
      chk("w55_period", 32'(period), 10);
      chk("w55_high", 32'(high_time), 5);

      // Fastest waveform.
      wave(1, 1, 10);
      chk("w11_period", 32'(period), 2);
      chk("w11_high", 32'(high_time), 1);

      // Period exactly at MAX with a closing rise: normal update, not stuck.
      wave(254, 1, 3);
      chk("w254_period", 32'(period), 255);
      chk("w254_high", 32'(high_time), 254);
      chk("w254_stuck", 32'(stuck), 0);

      // Held high: one closing valid, then a single timeout valid.
      v0 = vcnt; repeat (300) cyc(1'b1);
      chk("hold1_count", 32'(vcnt - v0), 2);
      chk("hold1_period", 32'(period), 255);
      chk("hold1_high", 32'(high_time), 255);
      chk("hold1_stuck", 32'(stuck), 1);
      chk("hold1_level", 32'(stuck_level), 1);

      // A fall while stuck updates the level but keeps stuck set.
      repeat (5) cyc(1'b0);
      chk("fall_stuck", 32'(stuck), 1);
      chk("fall_level", 32'(stuck_level), 0);

      // The next rise clears stuck.
      v0 = vcnt; repeat (6) cyc(1'b1);
      chk("rise_unstuck", 32'(stuck), 0);

      // Held low after a high pulse.
      repeat (300) cyc(1'b0);
      chk("hold0_count", 32'(vcnt - v0), 1);
      chk("hold0_period", 32'(period), 255);
      chk("hold0_high", 32'(high_time), 0);
      chk("hold0_stuck", 32'(stuck), 1);
      chk("hold0_level", 32'(stuck_level), 0);

      // Reset pulsed in the middle of a 4/6 high phase.
      wave(4, 6, 2);
      cyc(1'b1); cyc(1'b1);
      reset = 1'b0;
      cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
      reset = 1'b1;
      repeat (4) cyc(1'b0);
      chk_zero("midrst");
      v0 = vcnt; wave(4, 6, 3);
      chk("midrst_count", 32'(vcnt - v0), 2);
      chk("midrst_period", 32'(period), 10);
      chk("midrst_high", 32'(high_time), 4);

      // Pin already high when reset releases: that counts as a rise.
      reset = 1'b0;
      repeat (3) cyc(1'b1);
      reset = 1'b1;
      v0 = vcnt; wave(4, 6, 2);
      chk("hirst_count", 32'(vcnt - v0), 1);
      chk("hirst_period", 32'(period), 10);
      chk("hirst_high", 32'(high_time), 4);

      // Random waveforms, long holds and occasional resets.
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            reset = 1'b0;
            n = $urandom_range(1, 4);
            repeat (n) cyc(1'($urandom_range(0, 1)));
            reset = 1'b1;
         end else if (r == 1) begin
            n = $urandom_range(240, 300);
            repeat (n) cyc(1'($urandom_range(0, 1)) ? 1'b1 : pwm_in);
         end else begin
            h = $urandom_range(1, 30);
            l = $urandom_range(1, 30);
            wave(h, l, $urandom_range(1, 4));
         end
      end
      repeat (8) cyc(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of period/high counters and outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (minimum 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets on next clk edge).
REQ-005 SHALL have port pwm_in  input  1  asynchronous PWM waveform, e.g. LED output of the PWM generator.
REQ-006 SHALL have port period  output  CNT_W  last measured period in clk cycles.
REQ-007 SHALL have port high_time  output  CNT_W  last measured high time in clk cycles.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when period/high_time update.
REQ-009 SHALL have port stuck  output  1  level; 1 while pwm_in has had no edge for MAX cycles.
REQ-010 SHALL have port stuck_level  output  1  synchronized pwm_in level latched when stuck sets.

Function
REQ-011 SHALL pass pwm_in through SYNC_STAGES flops, then one history flop for edge detect; rise = s & ~s_d, fall = ~s & s_d.
REQ-012 SHALL define MAX = 2^CNT_W - 1; counters saturate at MAX, never wrap.
REQ-013 SHALL implement FSM states WAIT_RISE, HIGH, LOW.
REQ-014 WAIT_RISE: ignore fall; on rise -> HIGH, per_cnt=1, hi_cnt=1; no output update.
REQ-015 HIGH: per_cnt++ and hi_cnt++ each cycle; on fall -> LOW (hi_cnt frozen, per_cnt++).
REQ-016 LOW: per_cnt++ each cycle; on rise -> load period=per_cnt, high_time=hi_cnt, pulse valid next cycle, restart per_cnt=1, hi_cnt=1, -> HIGH.
REQ-017 Measurement SHALL be exact: input high H cycles, low L cycles (each >=1) gives period=H+L, high_time=H.
REQ-018 valid SHALL be registered, asserted exactly the cycle after the closing rise is detected, same cycle period/high_time show new values.
REQ-019 period/high_time SHALL hold between updates.
REQ-020 Timeout: if per_cnt reaches MAX in HIGH or LOW with no edge, stuck=1, stuck_level=s, period=MAX, high_time=MAX if s==1 else 0, valid pulses once, FSM -> WAIT_RISE.
REQ-021 While stuck=1 no further valid pulses; stuck clears on the next detected rise (same cycle FSM enters HIGH).
REQ-022 A fall detected in WAIT_RISE after timeout SHALL update stuck_level to 0 but not clear stuck.
REQ-023 A rise and saturation in the same cycle SHALL be treated as rise (normal update, no stuck).
REQ-024 Latency pwm_in pin edge to FSM response SHALL be SYNC_STAGES+1 cycles, equal for both edges, so H and L are unbiased.

Reset
REQ-025 On reset==0 at clk edge: FSM=WAIT_RISE, per_cnt=0, hi_cnt=0, period=0, high_time=0, valid=0, stuck=0, stuck_level=0, sync/history flops=0.
REQ-026 Reset mid-measurement SHALL discard partial counts; first valid after release requires a rise then a complete period.
REQ-027 If pwm_in is high at reset release, synchronized rise SHALL be detected and start measurement.

Verification
REQ-028 CNT_W=8; pwm_in high 3 / low 7 repeating -> valid once per 10 cycles, period=10, high_time=3, first valid after second rise.
REQ-029 pwm_in high 1 / low 1 -> period=2, high_time=1 every 2 cycles; high 254 / low 1 -> period=255, high_time=254, stuck stays 0.
REQ-030 pwm_in held 1 after one rise -> 255 cycles later single valid, period=255, high_time=255, stuck=1, stuck_level=1; next rise after low clears stuck.
REQ-031 pwm_in held 0 after a high pulse -> period=255, high_time=0, stuck=1, stuck_level=0.
REQ-032 reset pulsed low mid-HIGH of a 4/6 waveform -> outputs 0, no valid until one full period after first post-reset rise, then period=10, high_time=4.
REQ-033 Change waveform from 3/7 to 5/5 mid-stream -> exactly one transitional sample (period=10, high_time=5 at first complete new period); no spurious valid.
